// File: rtl/video_pattern_pkg.sv
// Shared types and width helpers for the AXI4-Stream video test-pattern source.
package video_pattern_pkg;

  typedef enum logic [2:0] {
    PAT_SOLID       = 3'd0,
    PAT_CHECKER     = 3'd1,
    PAT_GRADIENT    = 3'd2,
    PAT_COUNTER     = 3'd3,
    PAT_COLORBARS   = 3'd4,
    PAT_MOVING_RAMP = 3'd5
  } pattern_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK,
    ST_DONE
  } gen_state_t;

  localparam int FRAME_CNT_W = 16;

  function automatic int pix_width(input int num_comp, input int bits_per_comp);
    return num_comp * bits_per_comp;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axis_video_pattern_src_pixel_calc.sv
// Combinational pixel generator: one pixel from its coordinates, frame count and pattern.
module pattern_pixel_calc
  import video_pattern_pkg::*;
#(
  parameter int NUM_COMP      = 3,
  parameter int BITS_PER_COMP = 8,
  parameter int FRAME_WIDTH   = 1920,
  parameter int CHECK_LOG2    = 3,
  parameter int XW            = 11,
  parameter int YW            = 11,
  parameter logic [NUM_COMP*BITS_PER_COMP-1:0] SOLID_COLOR = '0
) (
  input  logic [XW-1:0]                       x,
  input  logic [YW-1:0]                       y,
  input  logic [FRAME_CNT_W-1:0]              frame_cnt,
  input  pattern_t                            pattern,
  output logic [NUM_COMP*BITS_PER_COMP-1:0]   pixel
);

  logic [2:0]                             bar;
  logic                                   chk_on;
  logic [BITS_PER_COMP-1:0]               v;
  logic [NUM_COMP*BITS_PER_COMP-1:0]      bars_pix;

  assign bar    = 3'((32'(x) * 32'd8) / 32'(FRAME_WIDTH));
  assign chk_on = (((32'(x) >> CHECK_LOG2) ^ (32'(y) >> CHECK_LOG2)) & 32'd1) != 32'd0;

  // Colour bars cycle the three primaries' bits across however many components exist.
  for (genvar c = 0; c < NUM_COMP; c++) begin : g_bar
    assign bars_pix[c*BITS_PER_COMP +: BITS_PER_COMP] = bar[c % 3] ? '1 : '0;
  end

  // Scalar ramp value for the replicated-component patterns (truncated to component width)
  always_comb begin
    v = '0;
    case (pattern)
      PAT_GRADIENT:    v = BITS_PER_COMP'(32'(x) + 32'(y));
      PAT_COUNTER:     v = BITS_PER_COMP'(32'(x));
      PAT_MOVING_RAMP: v = BITS_PER_COMP'(32'(x) + 32'(frame_cnt));
      default:         v = '0;
    endcase
  end

  // Pattern mux; unused encodings fall back to the solid colour
  always_comb begin
    pixel = SOLID_COLOR;
    case (pattern)
      PAT_CHECKER:                                pixel = chk_on ? '1 : '0;
      PAT_GRADIENT, PAT_COUNTER, PAT_MOVING_RAMP: pixel = {NUM_COMP{v}};
      PAT_COLORBARS:                              pixel = bars_pix;
      default:                                    pixel = SOLID_COLOR;
    endcase
  end

endmodule

// File: rtl/axis_video_pattern_src.sv
// AXI4-Stream video test-pattern source: FSM, x/y/blank counters and output register.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | stopped; waits for enable, first beat loads on the same edge
// ST_ACTIVE | emitting beats of a line (incl. stalled tlast beat)
// ST_HBLANK | tvalid low for HBLANK_CYC cycles after a line's tlast handshake
// ST_VBLANK | extra VBLANK_CYC idle cycles after the frame's last line
// ST_DONE   | num_frames reached; waits for enable to drop
module axis_video_pattern_src
  import video_pattern_pkg::*;
#(
  parameter int PIX_PER_BEAT  = 2,
  parameter int NUM_COMP      = 3,
  parameter int BITS_PER_COMP = 8,
  parameter int FRAME_WIDTH   = 1920,
  parameter int FRAME_HEIGHT  = 1080,
  parameter int HBLANK_CYC    = 0,
  parameter int VBLANK_CYC    = 0,
  parameter int CHECK_LOG2    = 3,
  parameter logic [NUM_COMP*BITS_PER_COMP-1:0] SOLID_COLOR = 24'h00FF00
) (
  input  logic                                          clk,
  input  logic                                          reset_n,
  input  logic                                          enable,
  input  logic [2:0]                                    pattern_sel,
  input  logic [15:0]                                   num_frames,
  output logic                                          m_axis_tvalid,
  output logic [PIX_PER_BEAT*NUM_COMP*BITS_PER_COMP-1:0] m_axis_tdata,
  output logic                                          m_axis_tlast,
  output logic                                          m_axis_tuser,
  input  logic                                          m_axis_tready,
  output logic                                          busy,
  output logic                                          done,
  output logic [15:0]                                   frame_cnt
);

  localparam int PIXW           = pix_width(NUM_COMP, BITS_PER_COMP);
  localparam int TDATA_W        = PIX_PER_BEAT * PIXW;
  localparam int BEATS_PER_LINE = FRAME_WIDTH / PIX_PER_BEAT;
  localparam int XBW            = cnt_width(BEATS_PER_LINE - 1);
  localparam int XW             = cnt_width(FRAME_WIDTH - 1);
  localparam int YW             = cnt_width(FRAME_HEIGHT - 1);
  localparam int BLW            = cnt_width((HBLANK_CYC > VBLANK_CYC) ? HBLANK_CYC : VBLANK_CYC);
  localparam logic [XBW-1:0] XB_LAST = XBW'(BEATS_PER_LINE - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(FRAME_HEIGHT - 1);

  if (FRAME_WIDTH % PIX_PER_BEAT != 0) begin : g_bad_width
    $error("FRAME_WIDTH must be a multiple of PIX_PER_BEAT");
  end

  gen_state_t             state_q, state_d;
  logic [XBW-1:0]         xb_q, xb_d;
  logic [YW-1:0]          y_q, y_d;
  logic [BLW-1:0]         blank_q, blank_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  pattern_t               pat_q, pat_d, pat_use;
  logic                   tvalid_q, tlast_q, tuser_q;
  logic [TDATA_W-1:0]     tdata_q, beat_data;
  logic                   load_en, load_beat, sof_pos;
  logic                   line_end, hb_done, boundary;

  // xb/y always point at the next beat to load, so x=y=0 marks a start-of-frame load.
  assign sof_pos = (xb_q == '0) && (y_q == '0);
  assign load_en = !tvalid_q || m_axis_tready;
  assign pat_use = sof_pos ? pattern_t'(pattern_sel) : pat_q;

  for (genvar i = 0; i < PIX_PER_BEAT; i++) begin : g_pix
    logic [XW-1:0] x_pix;
    assign x_pix = XW'(32'(xb_q) * 32'(PIX_PER_BEAT) + 32'(i));
    pattern_pixel_calc #(
      .NUM_COMP      (NUM_COMP),
      .BITS_PER_COMP (BITS_PER_COMP),
      .FRAME_WIDTH   (FRAME_WIDTH),
      .CHECK_LOG2    (CHECK_LOG2),
      .XW            (XW),
      .YW            (YW),
      .SOLID_COLOR   (SOLID_COLOR)
    ) u_calc (
      .x         (x_pix),
      .y         (y_q),
      .frame_cnt (frame_cnt_d),
      .pattern   (pat_use),
      .pixel     (beat_data[i*PIXW +: PIXW])
    );
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      xb_q        <= '0;
      y_q         <= '0;
      blank_q     <= '0;
      frame_cnt_q <= '0;
      pat_q       <= PAT_SOLID;
    end else begin
      state_q     <= state_d;
      xb_q        <= xb_d;
      y_q         <= y_d;
      blank_q     <= blank_d;
      frame_cnt_q <= frame_cnt_d;
      pat_q       <= pat_d;
    end
  end

  // Next-state logic: line end -> hblank -> (last line) vblank -> frame boundary decision
  always_comb begin
    state_d     = state_q;
    xb_d        = xb_q;
    y_d         = y_q;
    blank_d     = blank_q;
    frame_cnt_d = frame_cnt_q;
    pat_d       = pat_q;
    load_beat   = 1'b0;
    line_end    = 1'b0;
    hb_done     = 1'b0;
    boundary    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_ACTIVE;
          frame_cnt_d = '0;
          load_beat   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (load_en) begin
          if (tvalid_q && tlast_q) line_end  = 1'b1;
          else                     load_beat = 1'b1;
        end
      end
      ST_HBLANK: begin
        if (blank_q == '0) hb_done = 1'b1;
        else               blank_d = blank_q - BLW'(1);
      end
      ST_VBLANK: begin
        if (blank_q == '0) boundary = 1'b1;
        else               blank_d  = blank_q - BLW'(1);
      end
      ST_DONE: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (line_end) begin
      if (HBLANK_CYC != 0) begin
        state_d = ST_HBLANK;
        blank_d = BLW'(HBLANK_CYC - 1);
      end else begin
        hb_done = 1'b1;
      end
    end

    // Counters advanced past the tlast beat already, so y==0 here means the frame just ended.
    if (hb_done) begin
      if (y_q != '0) begin
        state_d   = ST_ACTIVE;
        load_beat = 1'b1;
      end else if (VBLANK_CYC != 0) begin
        state_d = ST_VBLANK;
        blank_d = BLW'(VBLANK_CYC - 1);
      end else begin
        boundary = 1'b1;
      end
    end

    if (boundary) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
      if ((num_frames != '0) && (frame_cnt_d == num_frames)) begin
        state_d = ST_DONE;
      end else if (!enable) begin
        state_d = ST_IDLE;
      end else begin
        state_d   = ST_ACTIVE;
        load_beat = 1'b1;
      end
    end

    if (load_beat) begin
      if (sof_pos) pat_d = pattern_t'(pattern_sel);
      if (xb_q == XB_LAST) begin
        xb_d = '0;
        y_d  = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        xb_d = xb_q + XBW'(1);
      end
    end
  end

  // Output register: load a new beat, or drop valid once the held beat has been taken
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tdata_q  <= '0;
    end else if (load_beat) begin
      tvalid_q <= 1'b1;
      tlast_q  <= (xb_q == XB_LAST);
      tuser_q  <= sof_pos;
      tdata_q  <= beat_data;
    end else if (load_en) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign frame_cnt     = frame_cnt_q;

endmodule
